// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register bank.
package regfile_pkg;
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/regfile_if.sv
// Write/read bus of the register bank; master drives ops and addresses, slave returns data and flags.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  op_e              op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             carry;
  logic             zero;

  modport master (
    output we, op, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, carry, zero
  );

  modport slave (
    input  we, op, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, carry, zero
  );
endinterface

// File: rtl/regfile_upd.sv
// Combinational write-result unit shared by the store path and the read bypass.
module regfile_upd
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] res,
  output logic             carry
);
  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;

  // Carry/borrow is the extra top bit of the widened sum/difference.
  assign inc_w = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_w = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res   = wdata;
    carry = 1'b0;
    case (op)
      OP_LOAD: begin
        res   = wdata;
        carry = 1'b0;
      end
      OP_INC: begin
        res   = inc_w[WIDTH-1:0];
        carry = inc_w[WIDTH];
      end
      OP_DEC: begin
        res   = dec_w[WIDTH-1:0];
        carry = dec_w[WIDTH];
      end
      OP_CLR: begin
        res   = '0;
        carry = 1'b0;
      end
      default: begin
        res   = wdata;
        carry = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/regfile.sv
// DEPTH x WIDTH register bank, one write port with LOAD/INC/DEC/CLR and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward the pending write result to a read port addressing it.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             wr_hit;
  logic             wr_ok;
  logic [WIDTH-1:0] res;
  logic             upd_carry;

  // Address decode doubles as the range check: no match means out of range.
  always_comb begin
    cur    = '0;
    rd_a   = '0;
    rd_b   = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.waddr == AW'(i)) begin
        cur    = regs_q[i];
        wr_hit = 1'b1;
      end
      if (bus.raddr_a == AW'(i)) rd_a = regs_q[i];
      if (bus.raddr_b == AW'(i)) rd_b = regs_q[i];
    end
  end

  assign wr_ok = bus.we && wr_hit;

  regfile_upd #(.WIDTH(WIDTH)) u_upd (
    .op    (bus.op),
    .cur   (cur),
    .wdata (bus.wdata),
    .res   (res),
    .carry (upd_carry)
  );

  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.waddr == AW'(i)) regs_d[i] = res;
      end
      carry_d = upd_carry;
      zero_d  = (res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q  <= '{default: '0};
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    bus.rdata_a = (wr_ok && (bus.raddr_a == bus.waddr)) ? res : rd_a;
    bus.rdata_b = (wr_ok && (bus.raddr_b == bus.waddr)) ? res : rd_b;
`else
    bus.rdata_a = rd_a;
    bus.rdata_b = rd_b;
`endif
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_regfile.sv
// Directed scoreboard bench for regfile (DEPTH=3 so that address 3 is out of range).
module tb_regfile;
  import regfile_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] exp;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] m_reg [DEPTH];
  logic             m_c;
  logic             m_z;

  task automatic push(input string tag, input logic [WIDTH-1:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [WIDTH-1:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic model_write(input op_e op, input int addr, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] old;
    logic [WIDTH-1:0] r;
    if (addr >= DEPTH) return;
    old = m_reg[addr];
    case (op)
      OP_LOAD: begin r = d;            m_c = 1'b0;                    end
      OP_INC:  begin r = old + 8'd1;   m_c = (old == 8'hFF);          end
      OP_DEC:  begin r = old - 8'd1;   m_c = (old == 8'h00);          end
      default: begin r = '0;           m_c = 1'b0;                    end
    endcase
    m_reg[addr] = r;
    m_z = (r == 8'h00);
  endtask

  task automatic check_flags(input string tag);
    push({tag, "_carry"}, WIDTH'(m_c));
    push({tag, "_zero"}, WIDTH'(m_z));
    pop_check(WIDTH'(bus.carry));
    pop_check(WIDTH'(bus.zero));
  endtask

  // One accepted write, then read back the target with we dropped.
  task automatic do_write(input op_e op, input int addr, input logic [WIDTH-1:0] d, input string tag);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.op    = op;
    bus.waddr = AW'(addr);
    bus.wdata = d;
    model_write(op, addr, d);
    push({tag, "_reg"}, m_reg[addr]);
    @(posedge clk);
    #1;
    bus.we      = 1'b0;
    bus.raddr_a = AW'(addr);
    #1;
    pop_check(bus.rdata_a);
    check_flags(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] old;
    bus.we      = 1'b0;
    bus.op      = OP_LOAD;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.raddr_a = '0;
    bus.raddr_b = AW'(1);
    model_reset();

    #1;
    push("rst_rdata_a", 8'h00); pop_check(bus.rdata_a);
    push("rst_rdata_b", 8'h00); pop_check(bus.rdata_b);
    check_flags("rst");
    @(negedge clk);
    rst = 1'b1;

    // Preload, set both flags, then reset asynchronously between edges.
    do_write(OP_LOAD, 0, 8'h5A, "pre_ld0");
    do_write(OP_LOAD, 2, 8'h33, "pre_ld2");
    do_write(OP_LOAD, 1, 8'hFF, "pre_ld1");
    do_write(OP_INC,  1, 8'h00, "pre_inc1");
    bus.raddr_a = AW'(0);
    bus.raddr_b = AW'(2);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    push("async_rst_a", 8'h00); pop_check(bus.rdata_a);
    push("async_rst_b", 8'h00); pop_check(bus.rdata_b);
    check_flags("async_rst");
    rst = 1'b1;

    do_write(OP_LOAD, 2, 8'h3C, "ld2");
    do_write(OP_LOAD, 0, 8'h81, "ld0");
    @(negedge clk);
    bus.raddr_a = AW'(2);
    bus.raddr_b = AW'(0);
    #1;
    push("dual_read_a", 8'h3C); pop_check(bus.rdata_a);
    push("dual_read_b", 8'h81); pop_check(bus.rdata_b);
    check_flags("dual_read");

    do_write(OP_LOAD, 1, 8'hFF, "wrap_ld");
    do_write(OP_INC,  1, 8'h00, "wrap_inc");
    do_write(OP_DEC,  1, 8'h00, "wrap_dec");
    do_write(OP_DEC,  1, 8'h00, "wrap_dec2");

    // Three INCs on consecutive edges.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.op    = OP_INC;
    bus.waddr = AW'(0);
    for (int k = 0; k < 3; k++) model_write(OP_INC, 0, 8'h00);
    push("b2b_inc_reg", m_reg[0]);
    repeat (3) @(posedge clk);
    #1;
    bus.we      = 1'b0;
    bus.raddr_a = AW'(0);
    #1;
    pop_check(bus.rdata_a);
    check_flags("b2b_inc");

    do_write(OP_CLR, 1, 8'h00, "clr1");

    // Out-of-range write must leave state and flags untouched.
    @(negedge clk);
    bus.we      = 1'b1;
    bus.op      = OP_LOAD;
    bus.waddr   = AW'(3);
    bus.wdata   = 8'h77;
    bus.raddr_a = AW'(3);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    #1;
    push("oor_read", 8'h00); pop_check(bus.rdata_a);
    check_flags("oor");
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr_a = AW'(i);
      #1;
      push($sformatf("oor_keep_reg%0d", i), m_reg[i]);
      pop_check(bus.rdata_a);
    end

    // CLR with we low for five edges.
    @(negedge clk);
    bus.we      = 1'b0;
    bus.op      = OP_CLR;
    bus.waddr   = AW'(2);
    bus.raddr_b = AW'(2);
    repeat (5) @(posedge clk);
    #1;
    push("hold_reg2", 8'h3C); pop_check(bus.rdata_b);
    check_flags("hold");

    // Same-cycle read of the register being written.
    do_write(OP_LOAD, 0, 8'h10, "byp_ld");
    @(negedge clk);
    bus.we      = 1'b1;
    bus.op      = OP_INC;
    bus.waddr   = AW'(0);
    bus.raddr_a = AW'(0);
    old = m_reg[0];
    model_write(OP_INC, 0, 8'h00);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("byp_inc_pre", m_reg[0]);
`else
    push("byp_inc_pre", old);
`endif
    pop_check(bus.rdata_a);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    #1;
    push("byp_inc_post", 8'h11); pop_check(bus.rdata_a);
    check_flags("byp_inc");

    @(negedge clk);
    bus.we      = 1'b1;
    bus.op      = OP_CLR;
    bus.waddr   = AW'(2);
    bus.raddr_b = AW'(2);
    old = m_reg[2];
    model_write(OP_CLR, 2, 8'h00);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("byp_clr_pre", m_reg[2]);
`else
    push("byp_clr_pre", old);
`endif
    pop_check(bus.rdata_b);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    #1;
    push("byp_clr_post", 8'h00); pop_check(bus.rdata_b);
    check_flags("byp_clr");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
